// File: rtl/video_pkg.sv
// Shared definitions for the video timing generator.
//
// Contents:
//   DEF_*          default horizontal/vertical timing and grid pitch
//                  (800x480 panel timing, 16-pixel grid)
//   video_mode_e   output pattern selector
//   bar_colour()   colour of each of the eight vertical colour bars
package video_pkg;

  localparam int DEF_HDISP  = 800;
  localparam int DEF_VDISP  = 480;
  localparam int DEF_HFP    = 40;
  localparam int DEF_HPULSE = 48;
  localparam int DEF_HBP    = 40;
  localparam int DEF_VFP    = 12;
  localparam int DEF_VPULSE = 3;
  localparam int DEF_VBP    = 40;
  localparam int DEF_GRID   = 16;

  typedef enum logic [1:0] {
    MODE_BLACK  = 2'd0,
    MODE_GRID   = 2'd1,
    MODE_BARS   = 2'd2,
    MODE_STREAM = 2'd3
  } video_mode_e;

  // Classic bar order, left to right.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    logic [23:0] c;
    case (idx)
      3'd0:    c = 24'hFFFFFF; // white
      3'd1:    c = 24'hFFFF00; // yellow
      3'd2:    c = 24'h00FFFF; // cyan
      3'd3:    c = 24'h00FF00; // green
      3'd4:    c = 24'hFF00FF; // magenta
      3'd5:    c = 24'hFF0000; // red
      3'd6:    c = 24'h0000FF; // blue
      default: c = 24'h000000; // black
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern.sv
// Combinational test-pattern colour generator.
//
// Ports:
//   x     in  XW  active-area column
//   y     in  YW  active-area row
//   mode  in  2   pattern select (video_mode_e encoding)
//   rgb   out 24  colour for (x, y); black for MODE_BLACK and MODE_STREAM
//                 (streamed pixels are handled by the timing generator)
module video_pattern
  import video_pkg::*;
#(
  parameter int HDISP = DEF_HDISP,
  parameter int GRID  = DEF_GRID,
  parameter int XW    = $clog2(DEF_HDISP),
  parameter int YW    = $clog2(DEF_VDISP)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    mode,
  output logic [23:0]   rgb
);

  // Bars are HDISP/8 wide; any remainder columns on the right stay black.
  localparam int BAR_W = (HDISP >= 8) ? HDISP / 8 : 1;

  int   bar_idx;
  logic on_grid;

  always_comb begin
    bar_idx = int'(x) / BAR_W;
    if (bar_idx > 7) bar_idx = 7;
    // GRID is a power of two, so the modulo reduces to a low-bit test.
    on_grid = ((int'(x) % GRID) == 0) || ((int'(y) % GRID) == 0);
    rgb     = 24'h000000;
    case (mode)
      MODE_GRID: rgb = on_grid ? 24'hFFFFFF : 24'h000000;
      MODE_BARS: rgb = bar_colour(3'(bar_idx));
      default:   rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with built-in test patterns and a streamed-pixel
// input.
//
// Each line/frame is laid out as front porch, sync, back porch, active.
// All video outputs are registered one cycle behind the h/v counters.
//
// Ports:
//   pixel_clk      in  1   pixel clock
//   pixel_rst_n    in  1   asynchronous active-low reset
//   enable         in  1   run timing; when low counters sit at (0,0)
//   mode           in  2   0 black / 1 grid / 2 colour bars / 3 stream,
//                          sampled only when counters are at (0,0)
//   pix_data       in  24  streamed RGB pixel
//   pix_valid      in  1   source has a pixel available
//   pix_ready      out 1   generator consumes a pixel this cycle
//   clr_underflow  in  1   clears the underflow flag
//   underflow      out 1   sticky: a pixel was needed but pix_valid was low
//   HS, VS         out 1   active-low syncs
//   BLANK          out 1   1 = active video
//   RGB            out 24  pixel colour, 0 outside the active area
//   frame_start    out 1   one-cycle pulse for counter position (0,0)
//   x, y           out     active-area coordinates, 0 outside active area
module video_timing_gen
  import video_pkg::*;
#(
  parameter int HDISP  = DEF_HDISP,
  parameter int VDISP  = DEF_VDISP,
  parameter int HFP    = DEF_HFP,
  parameter int HPULSE = DEF_HPULSE,
  parameter int HBP    = DEF_HBP,
  parameter int VFP    = DEF_VFP,
  parameter int VPULSE = DEF_VPULSE,
  parameter int VBP    = DEF_VBP,
  parameter int GRID   = DEF_GRID
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst_n,
  input  logic                     enable,
  input  logic [1:0]               mode,
  input  logic [23:0]              pix_data,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic                     clr_underflow,
  output logic                     underflow,
  output logic                     HS,
  output logic                     VS,
  output logic                     BLANK,
  output logic [23:0]              RGB,
  output logic                     frame_start,
  output logic [$clog2(HDISP)-1:0] x,
  output logic [$clog2(VDISP)-1:0] y
);

  localparam int HSUP  = HFP + HPULSE + HBP;
  localparam int VSUP  = VFP + VPULSE + VBP;
  localparam int HSIZE = HSUP + HDISP;
  localparam int VSIZE = VSUP + VDISP;
  localparam int HW    = $clog2(HSIZE);
  localparam int VW    = $clog2(VSIZE);
  localparam int XW    = $clog2(HDISP);
  localparam int YW    = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST   = HW'(HSIZE - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(VSIZE - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(HSUP);
  localparam logic [VW-1:0] V_ACT    = VW'(VSUP);
  localparam logic [HW-1:0] HS_BEG   = HW'(HFP);
  localparam logic [HW-1:0] HS_END   = HW'(HFP + HPULSE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(VFP);
  localparam logic [VW-1:0] VS_END   = VW'(VFP + VPULSE - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [1:0]    mode_q, mode_d;
  logic          underflow_q, underflow_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d, fs_q, fs_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  logic          origin;
  logic          active;
  logic [XW-1:0] x_c;
  logic [YW-1:0] y_c;
  logic [23:0]   pat_rgb;

  // Counters
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  assign origin = (h_q == '0) && (v_q == '0);
  assign active = enable && (h_q >= H_ACT) && (v_q >= V_ACT);
  assign x_c    = active ? XW'(h_q - H_ACT) : '0;
  assign y_c    = active ? YW'(v_q - V_ACT) : '0;

  video_pattern #(
    .HDISP (HDISP),
    .GRID  (GRID),
    .XW    (XW),
    .YW    (YW)
  ) u_pattern (
    .x    (x_c),
    .y    (y_c),
    .mode (mode_q),
    .rgb  (pat_rgb)
  );

  // Stream handshake: pix_ready is a pure function of counter position,
  // enable and the latched mode, never of pix_valid. A pixel transfers on
  // any cycle with pix_ready & pix_valid. The display cannot stall, so
  // pix_ready & !pix_valid shows black and records an underflow instead.
  assign pix_ready = active && (mode_q == MODE_STREAM);

  always_comb begin
    // Mode is only sampled at the frame origin so a frame never mixes modes.
    mode_d      = origin ? mode : mode_q;

    underflow_d = clr_underflow ? 1'b0 : underflow_q;
    if (pix_ready && !pix_valid) underflow_d = 1'b1;

    hs_d    = !(enable && (h_q >= HS_BEG) && (h_q <= HS_END));
    vs_d    = !(enable && (v_q >= VS_BEG) && (v_q <= VS_END));
    blank_d = active;
    fs_d    = enable && origin;
    x_d     = x_c;
    y_d     = y_c;

    rgb_d = 24'h000000;
    if (active) begin
      if (mode_q == MODE_STREAM) rgb_d = pix_valid ? pix_data : 24'h000000;
      else                       rgb_d = pat_rgb;
    end
  end

  always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
    if (!pixel_rst_n) begin
      h_q         <= '0;
      v_q         <= '0;
      mode_q      <= MODE_BLACK;
      underflow_q <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_q     <= 1'b0;
      fs_q        <= 1'b0;
      rgb_q       <= 24'h000000;
      x_q         <= '0;
      y_q         <= '0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      mode_q      <= mode_d;
      underflow_q <= underflow_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      blank_q     <= blank_d;
      fs_q        <= fs_d;
      rgb_q       <= rgb_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  assign underflow   = underflow_q;
  assign HS          = hs_q;
  assign VS          = vs_q;
  assign BLANK       = blank_q;
  assign RGB         = rgb_q;
  assign frame_start = fs_q;
  assign x           = x_q;
  assign y           = y_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a tiny 8x4 raster (HSIZE=14, VSIZE=7).
module tb_video_timing_gen;

  localparam int HSIZE = 14;
  localparam int VSIZE = 7;
  localparam int FRAME = HSIZE * VSIZE;
  localparam int HSUP  = 6;
  localparam int VSUP  = 3;

  // clock / reset / stimulus signals
  logic        pixel_clk = 1'b0;
  logic        pixel_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_valid = 1'b0;
  logic        clr_underflow = 1'b0;

  logic        pix_ready, underflow, HS, VS, BLANK, frame_start;
  logic [23:0] RGB;
  logic [2:0]  x;
  logic [1:0]  y;

  int checks = 0;
  int errors = 0;
  int k;            // posedges since timing was started
  int frame_mode;   // mode the bench expects for the current frame
  int drop_a = -1;  // counter positions where pix_valid is withheld
  int drop_b = -1;
  int ready_cnt;
  logic exp_uf;
  logic [23:0] exp_q[$];

  logic [23:0] bar_tbl [8];

  always #5 pixel_clk = ~pixel_clk;

  video_timing_gen #(
    .HDISP(8), .VDISP(4), .HFP(2), .HPULSE(2), .HBP(2),
    .VFP(1), .VPULSE(1), .VBP(1), .GRID(4)
  ) dut (
    .pixel_clk     (pixel_clk),
    .pixel_rst_n   (pixel_rst_n),
    .enable        (enable),
    .mode          (mode),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .pix_ready     (pix_ready),
    .clr_underflow (clr_underflow),
    .underflow     (underflow),
    .HS            (HS),
    .VS            (VS),
    .BLANK         (BLANK),
    .RGB           (RGB),
    .frame_start   (frame_start),
    .x             (x),
    .y             (y)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check_val({tag, "_hs"}, 32'(HS), 32'd1);
    check_val({tag, "_vs"}, 32'(VS), 32'd1);
    check_val({tag, "_blank"}, 32'(BLANK), 32'd0);
    check_val({tag, "_rgb"}, 32'(RGB), 32'd0);
    check_val({tag, "_fs"}, 32'(frame_start), 32'd0);
    check_val({tag, "_x"}, 32'(x), 32'd0);
    check_val({tag, "_y"}, 32'(y), 32'd0);
    check_val({tag, "_ready"}, 32'(pix_ready), 32'd0);
  endtask

  function automatic logic [23:0] pattern_rgb(input int m, input int xx, input int yy);
    if (m == 1) return ((xx % 4 == 0) || (yy % 4 == 0)) ? 24'hFFFFFF : 24'h000000;
    if (m == 2) return bar_tbl[xx];
    return 24'h000000;
  endfunction

  // Drive inputs for the current counter position, clock once, then check
  // the registered outputs that belong to that position.
  task automatic step_check();
    int cur, h, v;
    logic act, exp_ready;
    logic [23:0] exp_rgb, got_exp;
    cur = k % FRAME;
    h = cur % HSIZE;
    v = cur / HSIZE;
    act = (h >= HSUP) && (v >= VSUP);
    if (cur == 0) frame_mode = int'(mode);
    if (act) pix_data = 24'h5A0000 | 24'((v - VSUP) << 8) | 24'(h - HSUP);
    else     pix_data = 24'h123456;
    pix_valid = !((cur == drop_a) || (cur == drop_b));
    exp_ready = act && (frame_mode == 3);
    check_val("pix_ready", 32'(pix_ready), 32'(exp_ready));
    if (pix_ready) ready_cnt++;
    if (!act)                 exp_rgb = 24'h0;
    else if (frame_mode == 3) exp_rgb = pix_valid ? pix_data : 24'h0;
    else                      exp_rgb = pattern_rgb(frame_mode, h - HSUP, v - VSUP);
    exp_q.push_back(exp_rgb);
    if (clr_underflow) exp_uf = 1'b0;
    if (exp_ready && !pix_valid) exp_uf = 1'b1;
    @(posedge pixel_clk);
    #1;
    k++;
    got_exp = exp_q.pop_front();
    check_val("rgb", 32'(RGB), 32'(got_exp));
    check_val("frame_start", 32'(frame_start), 32'(cur == 0));
    check_val("hs", 32'(HS), 32'(!(h == 2 || h == 3)));
    check_val("vs", 32'(VS), 32'(v != 1));
    check_val("blank", 32'(BLANK), 32'(act));
    check_val("x", 32'(x), act ? 32'(h - HSUP) : 32'd0);
    check_val("y", 32'(y), act ? 32'(v - VSUP) : 32'd0);
    check_val("underflow", 32'(underflow), 32'(exp_uf));
  endtask

  initial begin
    bar_tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    k = 0;
    exp_uf = 1'b0;
    ready_cnt = 0;
    frame_mode = 0;

    // reset state, even with enable high
    enable = 1'b1;
    mode = 2'd1;
    repeat (3) @(posedge pixel_clk);
    #1;
    idle_check("reset");
    check_val("reset_underflow", 32'(underflow), 32'd0);

    // released but disabled: outputs stay idle
    enable = 1'b0;
    pixel_rst_n = 1'b1;
    repeat (4) begin
      @(posedge pixel_clk);
      #1;
      idle_check("disabled");
    end

    // grid frame, then a mid-frame switch to bars
    enable = 1'b1;
    k = 0;
    repeat (FRAME + 12) step_check();
    mode = 2'd2;
    while (k < 2 * FRAME + 63) step_check();

    // outputs now show bar 0 (white) at x=0,y=1; reset mid-line
    check_val("pre_rst1_rgb", 32'(RGB), 32'hFFFFFF);
    pixel_rst_n = 1'b0;
    #1;
    idle_check("async_rst1");
    check_val("async_rst1_uf", 32'(underflow), 32'd0);

    // restart from (0,0) and reset again inside the sync pulses
    @(posedge pixel_clk);
    #1;
    pixel_rst_n = 1'b1;
    k = 0;
    while (k < 17) step_check();
    check_val("pre_rst2_hs", 32'(HS), 32'd0);
    check_val("pre_rst2_vs", 32'(VS), 32'd0);
    pixel_rst_n = 1'b0;
    #1;
    idle_check("async_rst2");

    // streamed frame with a source that is always valid
    mode = 2'd3;
    @(posedge pixel_clk);
    #1;
    pixel_rst_n = 1'b1;
    k = 0;
    exp_uf = 1'b0;
    ready_cnt = 0;
    repeat (FRAME) step_check();
    check_val("ready_per_frame", 32'(ready_cnt), 32'd32);

    // starve the pixel at x=5,y=2, then set and clear together, then clear
    drop_a = 5 * HSIZE + 11;
    drop_b = 6 * HSIZE + 6;
    while (k < FRAME + drop_b) step_check();
    check_val("uf_sticky", 32'(underflow), 32'd1);
    clr_underflow = 1'b1;
    step_check();
    check_val("uf_set_and_clr", 32'(underflow), 32'd1);
    step_check();
    clr_underflow = 1'b0;
    check_val("uf_cleared", 32'(underflow), 32'd0);
    repeat (6) step_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against any unexpected stall.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog k=%0d", k);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter HDISP, default 800, active pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, active lines per frame.
REQ-003 SHALL have parameters HFP/HPULSE/HBP, defaults 40/48/40, horizontal front porch/sync/back porch in pixels.
REQ-004 SHALL have parameters VFP/VPULSE/VBP, defaults 12/3/40, vertical front porch/sync/back porch in lines.
REQ-005 SHALL have parameter GRID, default 16, grid pitch for test pattern (power of two).
REQ-006 SHALL have ports: pixel_clk in 1, pixel clock; pixel_rst_n in 1, reset, asynchronous, active-low.
REQ-007 SHALL have ports: enable in 1, run timing; mode in 2, 0 black / 1 grid / 2 colour bars / 3 stream.
REQ-008 SHALL have ports: pix_data in 24, streamed RGB; pix_valid in 1, source has data; pix_ready out 1, generator consumes pixel.
REQ-009 SHALL have ports: clr_underflow in 1, clears sticky flag; underflow out 1, sticky starvation flag.
REQ-010 SHALL have ports: HS out 1, VS out 1 (active-low syncs); BLANK out 1 (1 = active video); RGB out 24; frame_start out 1; x out $clog2(HDISP); y out $clog2(VDISP).

Function
REQ-011 SHALL count h 0..HSIZE-1 (HSIZE=HDISP+HFP+HPULSE+HBP), wrapping to 0; v increments on h wrap, wrapping 0 after VSIZE-1.
REQ-012 SHALL order each line/frame as front porch, sync, back porch, active; HS low for h in [HFP, HFP+HPULSE-1], VS low for v in [VFP, VFP+VPULSE-1].
REQ-013 SHALL define active as h>=HSUP and v>=VSUP (HSUP/VSUP = porch+sync sums); x=h-HSUP, y=v-VSUP when active, else 0.
REQ-014 SHALL register all video outputs: one cycle latency from counter state to HS/VS/BLANK/RGB/x/y.
REQ-015 SHALL pulse frame_start for exactly one cycle when counters equal (0,0), aligned with the registered outputs.
REQ-016 SHALL latch mode only at counter (0,0); mode changes mid-frame take effect next frame.
REQ-017 SHALL output mode 1 RGB=FFFFFF when x%GRID==0 or y%GRID==0, else 000000; mode 2 eight vertical bars of width HDISP/8 (white, yellow, cyan, green, magenta, red, blue, black); mode 0 black.
REQ-018 SHALL, in mode 3, drive pix_ready combinationally high exactly when counters address an active pixel and enable=1.
REQ-019 SHALL, on pix_ready&pix_valid, register RGB<=pix_data; on pix_ready&!pix_valid, register RGB<=0 and set underflow.
REQ-020 SHALL hold underflow until clr_underflow=1; simultaneous set and clear leaves underflow=1.
REQ-021 SHALL drive RGB=0 whenever not active, regardless of mode.
REQ-022 SHALL, with enable=0, hold counters at (0,0), pix_ready=0, HS=VS=1, BLANK=0, RGB=0, frame_start=0; on enable rising, first frame_start follows one cycle later.

Reset
REQ-023 SHALL on pixel_rst_n=0 immediately set counters 0, HS=1, VS=1, BLANK=0, RGB=0, x=y=0, frame_start=0, underflow=0, latched mode=0, pix_ready=0.
REQ-024 SHALL restart from (0,0) after reset released mid-frame; no partial-frame state retained.

Structure
REQ-025 SHALL place default timing constants and the mode enum typedef (MODE_BLACK, MODE_GRID, MODE_BARS, MODE_STREAM) in shared package video_pkg.
REQ-026 SHALL isolate pattern colour computation in sub-module video_pattern (combinational, inputs x, y, mode).

Verification (HDISP=8,VDISP=4,HFP=HPULSE=HBP=2,VFP=VPULSE=VBP=1: HSIZE=14, VSIZE=7)
REQ-027 SHALL check reset release with enable=1: frame_start high on cycle 1 only; HS low cycles 3-4 of each 14-cycle line; VS low for line 1 (cycles 15-28).
REQ-028 SHALL check mode 1 GRID=4: line v=3 BLANK=1 for 8 cycles, RGB FFFFFF for all; line v=4 FFFFFF at x=0 and x=4 only.
REQ-029 SHALL check mode 3 with pix_valid=1, pix_data=x: pix_ready high 32 cycles per frame, RGB sequence 0..7 per line, underflow=0.
REQ-030 SHALL check mode 3, pix_valid dropped at x=5,y=2: RGB=000000 that pixel, underflow=1 sticky until clr_underflow pulse.
REQ-031 SHALL check mode written 1->2 mid-frame: grid continues until next frame_start, bars thereafter; pixel_rst_n=0 mid-line forces HS=VS=1, RGB=0 asynchronously.
